round_scheduler: RTL and testbench
==================================

Name: round_scheduler

Overview:
- Sequences the timing of the reaction-time game: the 1 ms time base, the random pre-stimulus delay, the level-dependent response window and the 60 s game clock.
- Tells the game FSM and LED/score logic when the stimulus is live and whether each round was a hit or a miss.
- Sits between the random-value source, the switch-match detector (hit) and the display/score logic; replaces ad-hoc up/down counter control.

Parameters:
- CLKS_PER_MS, 50000, clk cycles per ms tick (50 MHz).
- MS_PER_SEC, 1000, ms ticks per game second.
- GAME_SECONDS, 60, game duration in seconds.
- MIN_DELAY_MS, 500, fixed part of the pre-stimulus delay.
- RAND_W, 11, width of random_delay (0..2047 ms added).
- BASE_WINDOW_MS, 1000, response window at level 0.
- WINDOW_STEP_MS, 200, window reduction per level.
- MIN_WINDOW_MS, 200, window floor.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin or restart a game.
- abort  in  1  one-cycle pulse: return to IDLE.
- level  in  4  current difficulty level.
- random_delay  in  RAND_W  random extra delay in ms, sampled on DELAY entry.
- hit  in  1  one-cycle pulse from the switch-match detector.
- ms_tick  out  1  one-cycle pulse every CLKS_PER_MS cycles while active.
- delay_active  out  1  high in DELAY.
- window_open  out  1  high in WINDOW; gates the stimulus LED.
- round_hit  out  1  one-cycle pulse: hit accepted in window.
- round_miss  out  1  one-cycle pulse: window expired without hit.
- early_press  out  1  one-cycle pulse: hit during DELAY.
- game_seconds  out  6  elapsed whole seconds, 0..GAME_SECONDS.
- game_over  out  1  high in OVER.
- busy  out  1  high in DELAY or WINDOW.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; every output 0.
- States: IDLE, DELAY, WINDOW, OVER.
- IDLE: start -> DELAY next cycle. Prescaler, ms counter and game_seconds cleared. delay_cnt loaded with MIN_DELAY_MS + random_delay; the sum is one bit wider than RAND_W, no overflow.
- Prescaler:
  - Counts 0..CLKS_PER_MS-1 only in DELAY/WINDOW.
  - ms_tick asserted in the cycle the prescaler equals CLKS_PER_MS-1.
  - First tick lands CLKS_PER_MS cycles after DELAY entry.
  - The prescaler is not reset between rounds.
- Game clock:
  - Each ms_tick increments ms_in_sec; at MS_PER_SEC-1 it wraps to 0 and game_seconds increments.
  - When game_seconds reaches GAME_SECONDS, the next state is OVER from DELAY or WINDOW.
  - This has priority over every round event in that cycle; no round_hit/round_miss is issued for the aborted round.
- DELAY:
  - delay_cnt decrements on ms_tick.
  - On ms_tick with delay_cnt==1 -> WINDOW, so DELAY lasts exactly delay_ms*CLKS_PER_MS cycles from the first tick boundary.
  - win_cnt is loaded on entry to WINDOW with max(BASE_WINDOW_MS - WINDOW_STEP_MS*level, MIN_WINDOW_MS). Compute signed/wide to avoid underflow, e.g. level 5 gives 200 and level 9 gives 200.
  - hit in DELAY -> early_press pulse; state unchanged.
- WINDOW:
  - win_cnt decrements on ms_tick.
  - hit -> round_hit pulse; reload delay_cnt from random_delay; -> DELAY.
  - ms_tick with win_cnt==1 and no hit -> round_miss pulse; reload delay; -> DELAY.
  - If hit and expiry occur in the same cycle, the hit wins.
  - round_hit/round_miss are asserted in the same cycle as the transition decision, i.e. combinationally on the WINDOW-exit cycle, registered into the next state.
- OVER: game_over=1 and game_seconds holds GAME_SECONDS. start -> DELAY (full restart as from IDLE). hit is ignored.
- abort in any state -> IDLE next cycle; counters cleared. abort has priority over start when both are asserted in the same cycle.
- start while in DELAY/WINDOW restarts the game: counters cleared, DELAY reloaded.
- level is sampled only at WINDOW entry; mid-window changes take effect next round.
- All outputs are registered except round_hit, round_miss, early_press and ms_tick, which are one-cycle pulses decoded from current state and counters.

Test Plan (CLKS_PER_MS=4, MS_PER_SEC=10, GAME_SECONDS=3, MIN_DELAY_MS=2, BASE_WINDOW_MS=10, WINDOW_STEP_MS=2, MIN_WINDOW_MS=2):
- Reset mid-DELAY: drop rst_n -> all outputs 0 immediately, state IDLE.
- start, random_delay=3, level=0 -> delay_active for 5 ms (20 cycles); window_open for 10 ms (40 cycles); round_miss pulses once; DELAY re-entered.
- level=1, hit 3 ms into window -> round_hit single pulse, window_open drops next cycle, no round_miss.
- level=7 -> window is 2 ms (floor), not negative.
- hit in the same cycle as the final window tick -> round_hit only.
- hit during DELAY -> early_press pulse, delay timing unchanged.
- Run 30 ms -> game_seconds steps 1,2,3. At 3: game_over=1, busy=0, no round pulse that cycle. start -> game_seconds=0, DELAY. abort plus start together -> IDLE.

Source files
------------

// File: rtl/round_scheduler_if.sv
// round_scheduler_if: game-side controls and timing/status outputs of the round scheduler.
interface round_scheduler_if #(
  parameter int RAND_W = 11
);
  logic              start;
  logic              abort;
  logic              hit;
  logic [3:0]        level;
  logic [RAND_W-1:0] random_delay;
  logic              ms_tick;
  logic              delay_active;
  logic              window_open;
  logic              round_hit;
  logic              round_miss;
  logic              early_press;
  logic [5:0]        game_seconds;
  logic              game_over;
  logic              busy;
  modport master (
    output start, abort, hit, level, random_delay,
    input  ms_tick, delay_active, window_open, round_hit, round_miss, early_press,
           game_seconds, game_over, busy
  );
  modport slave (
    input  start, abort, hit, level, random_delay,
    output ms_tick, delay_active, window_open, round_hit, round_miss, early_press,
           game_seconds, game_over, busy
  );
endinterface

// File: rtl/round_scheduler.sv
// round_scheduler: ms time base, random pre-stimulus delay, level-scaled response window and game clock.
module round_scheduler #(
  parameter int CLKS_PER_MS    = 50000,
  parameter int MS_PER_SEC     = 1000,
  parameter int GAME_SECONDS   = 60,
  parameter int MIN_DELAY_MS   = 500,
  parameter int RAND_W         = 11,
  parameter int BASE_WINDOW_MS = 1000,
  parameter int WINDOW_STEP_MS = 200,
  parameter int MIN_WINDOW_MS  = 200
) (
  input logic clk,
  input logic rst_n,
  round_scheduler_if.slave bus
);
  localparam int PW = $clog2(CLKS_PER_MS + 1);
  localparam int MW = $clog2(MS_PER_SEC + 1);
  localparam int DW = RAND_W + 1;
  localparam int WW = 16;
  typedef enum logic [1:0] {IDLE, DELAY, WINDOW, OVER} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] ms_q, ms_d;
  logic [5:0]    sec_q, sec_d;
  logic [DW-1:0] delay_q, delay_d, delay_load;
  logic [WW-1:0] win_q, win_d, win_load;
  logic          delay_active_q, delay_active_d;
  logic          window_open_q, window_open_d;
  logic          game_over_q, game_over_d;
  logic          busy_q, busy_d;
  logic          active, tick, sec_wrap, over_now, quiet;
  logic          round_hit, round_miss, early_press;
  int            win_raw;
  always_comb begin
    active      = state_q == DELAY || state_q == WINDOW;
    tick        = active && presc_q == PW'(CLKS_PER_MS - 1);
    sec_wrap    = tick && ms_q == MW'(MS_PER_SEC - 1);
    over_now    = sec_wrap && sec_q == 6'(GAME_SECONDS - 1);
    // game end, restart and abort all swallow the round events of their cycle
    quiet       = bus.abort || bus.start || over_now;
    delay_load  = DW'(MIN_DELAY_MS) + {1'b0, bus.random_delay};
    win_raw     = BASE_WINDOW_MS - WINDOW_STEP_MS * int'(bus.level);
    win_load    = win_raw < MIN_WINDOW_MS ? WW'(MIN_WINDOW_MS) : WW'(win_raw);
    round_hit   = state_q == WINDOW && bus.hit && !quiet;
    round_miss  = state_q == WINDOW && tick && win_q == WW'(1) && !bus.hit && !quiet;
    early_press = state_q == DELAY && bus.hit && !quiet;
    state_d     = state_q;
    presc_d     = active ? (tick ? '0 : presc_q + 1'b1) : '0;
    ms_d        = tick ? (sec_wrap ? '0 : ms_q + 1'b1) : ms_q;
    sec_d       = sec_wrap ? sec_q + 1'b1 : sec_q;
    delay_d     = state_q == DELAY && tick ? delay_q - 1'b1 : delay_q;
    win_d       = state_q == WINDOW && tick ? win_q - 1'b1 : win_q;
    if (bus.abort) begin
      state_d = IDLE;
      presc_d = '0;
      ms_d    = '0;
      sec_d   = '0;
      delay_d = '0;
      win_d   = '0;
    end else if (bus.start) begin
      state_d = DELAY;
      presc_d = '0;
      ms_d    = '0;
      sec_d   = '0;
      delay_d = delay_load;
    end else if (over_now) begin
      state_d = OVER;
    end else if (state_q == DELAY && tick && delay_q == DW'(1)) begin
      state_d = WINDOW;
      win_d   = win_load;
    end else if (round_hit || round_miss) begin
      state_d = DELAY;
      delay_d = delay_load;
    end
    delay_active_d = state_d == DELAY;
    window_open_d  = state_d == WINDOW;
    game_over_d    = state_d == OVER;
    busy_d         = delay_active_d || window_open_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      ms_q           <= '0;
      sec_q          <= '0;
      delay_q        <= '0;
      win_q          <= '0;
      delay_active_q <= 1'b0;
      window_open_q  <= 1'b0;
      game_over_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      ms_q           <= ms_d;
      sec_q          <= sec_d;
      delay_q        <= delay_d;
      win_q          <= win_d;
      delay_active_q <= delay_active_d;
      window_open_q  <= window_open_d;
      game_over_q    <= game_over_d;
      busy_q         <= busy_d;
    end
  end
  assign bus.ms_tick      = tick;
  assign bus.round_hit    = round_hit;
  assign bus.round_miss   = round_miss;
  assign bus.early_press  = early_press;
  assign bus.delay_active = delay_active_q;
  assign bus.window_open  = window_open_q;
  assign bus.game_over    = game_over_q;
  assign bus.busy         = busy_q;
  assign bus.game_seconds = sec_q;
endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: directed steps with a pulse scoreboard (1=hit, 2=miss, 4=early) for round_scheduler.
module tb_round_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int n;
  logic [2:0] exp_q[$];
  logic [2:0] m;
  round_scheduler_if #(.RAND_W(11)) ifc ();
  round_scheduler #(
    .CLKS_PER_MS(4), .MS_PER_SEC(10), .GAME_SECONDS(3), .MIN_DELAY_MS(2), .RAND_W(11),
    .BASE_WINDOW_MS(10), .WINDOW_STEP_MS(2), .MIN_WINDOW_MS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic adv(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic go(input int rd, input int lv);
    ifc.random_delay = 11'(rd);
    ifc.level = 4'(lv);
    ifc.start = 1'b1;
    adv(1);
    ifc.start = 1'b0;
  endtask
  task automatic press();
    ifc.hit = 1'b1;
    adv(1);
    ifc.hit = 1'b0;
  endtask
  task automatic measure(input int sel, output int k);
    k = 0;
    while ((sel == 0 ? ifc.delay_active : ifc.window_open) === 1'b1 && k < 200) begin
      adv(1);
      k++;
    end
  endtask
  always @(negedge clk) begin
    m = {ifc.early_press, ifc.round_miss, ifc.round_hit};
    if (m != 3'd0) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pulse", m, 0);
      else chk("sb_pulse", m, exp_q.pop_front());
    end
  end
  initial begin
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.hit = 1'b0;
    ifc.level = 4'd0;
    ifc.random_delay = 11'd0;
    adv(2);
    chk("rst_delay_active", ifc.delay_active, 0);
    chk("rst_window_open", ifc.window_open, 0);
    chk("rst_game_over", ifc.game_over, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_seconds", ifc.game_seconds, 0);
    chk("rst_ms_tick", ifc.ms_tick, 0);
    rst_n = 1'b1;
    adv(1);
    // async reset in the middle of DELAY
    go(3, 0);
    chk("t0_delay_active", ifc.delay_active, 1);
    chk("t0_busy", ifc.busy, 1);
    adv(4);
    rst_n = 1'b0;
    #1;
    chk("t0_async_delay_active", ifc.delay_active, 0);
    chk("t0_async_busy", ifc.busy, 0);
    chk("t0_async_ms_tick", ifc.ms_tick, 0);
    adv(1);
    rst_n = 1'b1;
    adv(1);
    chk("t0_idle_after_reset", ifc.delay_active, 0);
    // 5 ms delay, 10 ms window at level 0, miss
    go(3, 0);
    chk("t1_no_tick_at_entry", ifc.ms_tick, 0);
    adv(3);
    chk("t1_first_tick", ifc.ms_tick, 1);
    measure(0, n);
    chk("t1_delay_cycles", 3 + n, 20);
    chk("t1_window_open", ifc.window_open, 1);
    exp_q.push_back(3'd2);
    measure(1, n);
    chk("t1_window_cycles", n, 40);
    chk("t1_delay_reentered", ifc.delay_active, 1);
    // level 1, hit 3 ms into window
    go(0, 1);
    measure(0, n);
    chk("t2_delay_cycles", n, 8);
    adv(12);
    chk("t2_window_before_hit", ifc.window_open, 1);
    exp_q.push_back(3'd1);
    press();
    chk("t2_window_closed", ifc.window_open, 0);
    chk("t2_delay_after_hit", ifc.delay_active, 1);
    measure(0, n);
    chk("t2_delay_unaligned_prescaler", n, 7);
    // level 7 clamps to the 2 ms floor
    go(0, 7);
    measure(0, n);
    chk("t3_delay_cycles", n, 8);
    exp_q.push_back(3'd2);
    measure(1, n);
    chk("t3_window_floor_cycles", n, 8);
    chk("t3_delay_reentered", ifc.delay_active, 1);
    // hit on the final window tick: hit wins
    go(0, 7);
    measure(0, n);
    chk("t4_delay_cycles", n, 8);
    adv(7);
    chk("t4_final_tick", ifc.ms_tick, 1);
    exp_q.push_back(3'd1);
    press();
    chk("t4_window_closed", ifc.window_open, 0);
    chk("t4_delay_after_hit", ifc.delay_active, 1);
    // early press leaves delay timing unchanged
    go(3, 0);
    adv(5);
    exp_q.push_back(3'd4);
    press();
    chk("t5_still_delay", ifc.delay_active, 1);
    measure(0, n);
    chk("t5_delay_cycles", 6 + n, 20);
    // game clock; second window expires on the same tick the game ends
    go(3, 0);
    exp_q.push_back(3'd2);
    adv(39);
    chk("t6_sec_before_1", ifc.game_seconds, 0);
    adv(1);
    chk("t6_sec_1", ifc.game_seconds, 1);
    adv(39);
    chk("t6_sec_before_2", ifc.game_seconds, 1);
    adv(1);
    chk("t6_sec_2", ifc.game_seconds, 2);
    adv(39);
    chk("t6_sec_before_3", ifc.game_seconds, 2);
    chk("t6_last_tick", ifc.ms_tick, 1);
    chk("t6_no_miss_at_end", ifc.round_miss, 0);
    chk("t6_not_over_yet", ifc.game_over, 0);
    adv(1);
    chk("t6_sec_3", ifc.game_seconds, 3);
    chk("t6_game_over", ifc.game_over, 1);
    chk("t6_busy_low", ifc.busy, 0);
    chk("t6_window_low", ifc.window_open, 0);
    press();
    adv(5);
    chk("t6_sec_hold", ifc.game_seconds, 3);
    chk("t6_over_hold", ifc.game_over, 1);
    chk("t6_no_tick_over", ifc.ms_tick, 0);
    go(3, 0);
    chk("t7_restart_sec", ifc.game_seconds, 0);
    chk("t7_restart_delay", ifc.delay_active, 1);
    chk("t7_restart_over", ifc.game_over, 0);
    chk("t7_restart_busy", ifc.busy, 1);
    ifc.abort = 1'b1;
    ifc.start = 1'b1;
    adv(1);
    ifc.abort = 1'b0;
    ifc.start = 1'b0;
    chk("t8_abort_delay", ifc.delay_active, 0);
    chk("t8_abort_busy", ifc.busy, 0);
    chk("t8_abort_sec", ifc.game_seconds, 0);
    adv(2);
    chk("t8_idle_stays", ifc.busy, 0);
    chk("sb_all_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
